// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// Imported by rr_pick and fifo_wr_arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Grant index width; a single-bit index is kept for degenerate sizes.
  function automatic int gnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Beat counter width, wide enough to hold MAX_BURST.
  function automatic int cnt_w(input int m);
    return (m > 1) ? $clog2(m + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches upward from last_idx+1, wrapping modulo NUM_REQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int GNT_W   = gnt_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GNT_W-1:0]   last_idx,
  output logic               any_req,
  output logic [GNT_W-1:0]   pick_idx
);

  logic [GNT_W-1:0] cand;

  // Walk from farthest to nearest so the nearest set bit wins.
  always_comb begin
    any_req  = |req;
    pick_idx = '0;
    cand     = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = GNT_W'((int'(last_idx) + i) % NUM_REQ);
      if (req[cand]) begin
        pick_idx = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among producers.
// Grants hold for up to MAX_BURST beats and stall on FIFO full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int GNT_W      = gnt_w(NUM_REQ),
  localparam int CNT_W      = cnt_w(MAX_BURST)
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst_n,
  input  logic [NUM_REQ-1:0]            i_Req_Valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_Req_Data,
  output logic [NUM_REQ-1:0]            o_Req_Ready,
  output logic                          o_Wr_En,
  output logic [DATA_WIDTH-1:0]         o_Wr_Data,
  input  logic                          i_Full,
  output logic [GNT_W-1:0]              o_Grant_Id,
  output logic                          o_Busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
  localparam logic [GNT_W-1:0] LAST_ID  = GNT_W'(NUM_REQ - 1);

  state_t           state_q;
  state_t           state_d;
  logic [GNT_W-1:0] grant_q;
  logic [GNT_W-1:0] last_q;
  logic [CNT_W-1:0] cnt_q;

  logic             any_req;
  logic [GNT_W-1:0] pick;
  logic             in_grant;
  logic             req_g;
  logic             beat;
  logic             last_beat;
  logic             rel;

  logic [DATA_WIDTH-1:0] req_data [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_data[k] = i_Req_Data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req      (i_Req_Valid),
    .last_idx (last_q),
    .any_req  (any_req),
    .pick_idx (pick)
  );

  // Beat and release qualifiers for the current grant.
  always_comb begin
    in_grant  = (state_q == GRANT);
    req_g     = i_Req_Valid[grant_q];
    beat      = in_grant & req_g & ~i_Full;
    last_beat = beat & (cnt_q == LAST_CNT);
    rel       = in_grant & ~i_Full & (~req_g | last_beat);
  end

  // State register.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one idle bubble between grants.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = GRANT;
      GRANT:   if (rel)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant, round-robin pointer and beat counter.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      grant_q <= '0;
      last_q  <= LAST_ID;
      cnt_q   <= '0;
    end else if (!in_grant) begin
      if (any_req) begin
        grant_q <= pick;
        cnt_q   <= '0;
      end
    end else if (rel) begin
      last_q <= grant_q;
      cnt_q  <= '0;
    end else if (beat) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Write-port muxing and producer ready.
  always_comb begin
    o_Req_Ready = '0;
    o_Wr_En     = 1'b0;
    o_Wr_Data   = '0;
    o_Busy      = 1'b0;
    unique case (1'b1)
      in_grant: begin
        o_Req_Ready[grant_q] = ~i_Full;
        o_Wr_En              = beat;
        o_Wr_Data            = req_data[grant_q];
        o_Busy               = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_Grant_Id = grant_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a 4-entry FIFO model.
// Outputs sampled 1ns after the falling edge.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int GW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  valid = '0;
  logic [N*DW-1:0] data = '0;
  logic [N-1:0]  ready;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic [GW-1:0] gid;
  logic          busy;

  logic          force_full = 1'b0;
  logic          rd_en = 1'b1;
  logic [DW-1:0] fq [$];
  int            fsz = 0;
  int            wr_cnt = 0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] got;
  logic [15:0] exp;

  always #5 clk = ~clk;

  assign full = force_full | (fsz >= 4);

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .i_Clk       (clk),
    .i_Rst_n     (rst_n),
    .i_Req_Valid (valid),
    .i_Req_Data  (data),
    .o_Req_Ready (ready),
    .o_Wr_En     (wr_en),
    .o_Wr_Data   (wr_data),
    .i_Full      (full),
    .o_Grant_Id  (gid),
    .o_Busy      (busy)
  );

  // 4-entry FIFO model standing in for fifo_top.
  always @(posedge clk) begin
    if (wr_en) begin
      fq.push_back(wr_data);
      wr_cnt++;
    end
    if (rd_en && fq.size() > 0) void'(fq.pop_front());
    if (!rst_n) fq.delete();
    fsz <= fq.size();
  end

  function automatic logic [15:0] vec_g(input int g, input logic w,
                                        input logic [DW-1:0] d,
                                        input logic rdy);
    logic [3:0] r;
    r = rdy ? (4'b0001 << g) : 4'b0000;
    return {1'b1, 2'(g), r, w, d};
  endfunction

  function automatic logic [15:0] vec_i(input int g);
    return {1'b0, 2'(g), 4'b0000, 1'b0, 8'h00};
  endfunction

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    valid = '0;
    data = '0;
    force_full = 1'b0;
    rd_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wr_cnt = 0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    valid = 4'b1111;
    data = 32'hDEADBEEF;
    @(negedge clk);
    #1;
    got = {busy, gid, ready, wr_en, wr_data};
    exp = 16'h0000;
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want %h", got, exp);
    end
    @(negedge clk);
    #1;
    got = {busy, gid, ready, wr_en, wr_data};
    n_cmp++;
    if (got !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_hold: got %h want 0000", got);
    end
  endtask

  task automatic test_single;
    logic [7:0] dv [6] = '{8'hA0, 8'hA0, 8'hA1, 8'hA2, 8'hA2, 8'hA2};
    logic [3:0] vv [6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100,
                           4'b0000, 4'b0000};
    logic [15:0] ev [6];
    do_reset();
    ev[0] = vec_i(0);
    ev[1] = vec_g(2, 1'b1, 8'hA0, 1'b1);
    ev[2] = vec_g(2, 1'b1, 8'hA1, 1'b1);
    ev[3] = vec_g(2, 1'b1, 8'hA2, 1'b1);
    ev[4] = vec_g(2, 1'b0, 8'hA2, 1'b1);
    ev[5] = vec_i(2);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      valid = vv[c];
      data[23:16] = dv[c];
      #1;
      got = {busy, gid, ready, wr_en, wr_data};
      n_cmp++;
      if (got !== ev[c]) begin
        n_bad++;
        $display("FAIL single c%0d: got %h want %h", c, got, ev[c]);
      end
    end
    n_cmp++;
    if (wr_cnt !== 3) begin
      n_bad++;
      $display("FAIL single_beats: got %0d want 3", wr_cnt);
    end
  endtask

  task automatic test_all_four;
    int seq [5] = '{0, 1, 2, 3, 0};
    int g;
    do_reset();
    valid = 4'b1111;
    data = {8'h43, 8'h42, 8'h41, 8'h40};
    #1;
    got = {busy, gid, ready, wr_en, wr_data};
    n_cmp++;
    if (got !== vec_i(0)) begin
      n_bad++;
      $display("FAIL rr_start: got %h want %h", got, vec_i(0));
    end
    for (int s = 0; s < 5; s++) begin
      g = seq[s];
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        #1;
        got = {busy, gid, ready, wr_en, wr_data};
        exp = vec_g(g, 1'b1, 8'(8'h40 + g), 1'b1);
        n_cmp++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL rr g%0d b%0d: got %h want %h", s, b, got, exp);
        end
      end
      @(negedge clk);
      #1;
      got = {busy, gid, ready, wr_en, wr_data};
      n_cmp++;
      if (got !== vec_i(g)) begin
        n_bad++;
        $display("FAIL rr_bubble %0d: got %h want %h", s, got, vec_i(g));
      end
    end
    valid = '0;
    n_cmp++;
    if (wr_cnt !== 20) begin
      n_bad++;
      $display("FAIL rr_beats: got %0d want 20", wr_cnt);
    end
  endtask

  task automatic test_full_stall;
    do_reset();
    valid = 4'b0010;
    data[15:8] = 8'h5B;
    for (int c = 0; c < 11; c++) begin
      if (c > 0) @(negedge clk);
      force_full = (c >= 3 && c <= 7);
      #1;
      if (c == 0) exp = vec_i(0);
      else if (c == 10) exp = vec_i(1);
      else if (force_full) exp = vec_g(1, 1'b0, 8'h5B, 1'b0);
      else exp = vec_g(1, 1'b1, 8'h5B, 1'b1);
      got = {busy, gid, ready, wr_en, wr_data};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL full c%0d: got %h want %h", c, got, exp);
      end
    end
    valid = '0;
    n_cmp++;
    if (wr_cnt !== 4) begin
      n_bad++;
      $display("FAIL full_beats: got %0d want 4", wr_cnt);
    end
  endtask

  task automatic test_fill;
    do_reset();
    rd_en = 1'b0;
    valid = 4'b0001;
    data[7:0] = 8'h10;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clk);
      if (c >= 1 && c <= 4) data[7:0] = 8'(8'h10 + c - 1);
      if (c == 5) data[7:0] = 8'h14;
      #1;
      if (c == 0 || c == 5) exp = vec_i(0);
      else if (c == 6) exp = vec_g(0, 1'b0, 8'h14, 1'b0);
      else exp = vec_g(0, 1'b1, 8'(8'h10 + c - 1), 1'b1);
      got = {busy, gid, ready, wr_en, wr_data};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL fill c%0d: got %h want %h", c, got, exp);
      end
      if (c == 5) begin
        n_cmp++;
        if (full !== 1'b1) begin
          n_bad++;
          $display("FAIL fill_full: got %b want 1", full);
        end
      end
    end
    n_cmp++;
    if (fq.size() != 4) begin
      n_bad++;
      $display("FAIL fill_count: got %0d want 4", fq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (fq[i] !== 8'(8'h10 + i)) begin
          n_bad++;
          $display("FAIL fill_rd%0d: got %h want %h", i, fq[i], 8'(8'h10 + i));
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst;
    do_reset();
    valid = 4'b1000;
    data[31:24] = 8'h3C;
    #1;
    got = {busy, gid, ready, wr_en, wr_data};
    n_cmp++;
    if (got !== vec_i(0)) begin
      n_bad++;
      $display("FAIL rmb_idle: got %h want %h", got, vec_i(0));
    end
    @(negedge clk);
    #1;
    got = {busy, gid, ready, wr_en, wr_data};
    exp = vec_g(3, 1'b1, 8'h3C, 1'b1);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL rmb_beat1: got %h want %h", got, exp);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    got = {busy, gid, ready, wr_en, wr_data};
    n_cmp++;
    if (got !== 16'h0000) begin
      n_bad++;
      $display("FAIL rmb_async: got %h want 0000", got);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (wr_cnt !== 1) begin
      n_bad++;
      $display("FAIL rmb_writes: got %0d want 1", wr_cnt);
    end
    rst_n = 1'b1;
    valid = 4'b1001;
    data[7:0] = 8'h0D;
    #1;
    got = {busy, gid, ready, wr_en, wr_data};
    n_cmp++;
    if (got !== vec_i(0)) begin
      n_bad++;
      $display("FAIL rmb_release: got %h want %h", got, vec_i(0));
    end
    @(negedge clk);
    #1;
    got = {busy, gid, ready, wr_en, wr_data};
    exp = vec_g(0, 1'b1, 8'h0D, 1'b1);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL rmb_first: got %h want %h", got, exp);
    end
    valid = '0;
  endtask

  task automatic test_alternate;
    int seq [4] = '{1, 3, 1, 3};
    int g;
    do_reset();
    valid = 4'b1010;
    data = {8'h33, 8'h22, 8'h11, 8'h00};
    #1;
    got = {busy, gid, ready, wr_en, wr_data};
    n_cmp++;
    if (got !== vec_i(0)) begin
      n_bad++;
      $display("FAIL alt_start: got %h want %h", got, vec_i(0));
    end
    for (int s = 0; s < 4; s++) begin
      g = seq[s];
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        #1;
        got = {busy, gid, ready, wr_en, wr_data};
        exp = vec_g(g, 1'b1, 8'(8'h11 * g), 1'b1);
        n_cmp++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL alt g%0d b%0d: got %h want %h", s, b, got, exp);
        end
      end
      @(negedge clk);
      #1;
      got = {busy, gid, ready, wr_en, wr_data};
      n_cmp++;
      if (got !== vec_i(g)) begin
        n_bad++;
        $display("FAIL alt_bubble %0d: got %h want %h", s, got, vec_i(g));
      end
    end
    valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_full_stall();
    test_fill();
    test_reset_mid_burst();
    test_alternate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the sync FIFO (fifo_top) between NUM_REQ independent producers.
- Producers use a valid/ready handshake. Arbitration is round-robin.
- A grant holds for a bounded burst of up to MAX_BURST beats and respects the FIFO full flag.
- Sits directly in front of fifo_top's write side. The read side is untouched.

Parameters:
- NUM_REQ, 4, number of requesting producers (2..16).
- DATA_WIDTH, 8, data width; must match fifo_top DATA_WIDTH.
- MAX_BURST, 4, maximum beats written per grant before forced release (1..255).

Ports:
- i_Clk  input  1  system clock, rising edge.
- i_Rst_n  input  1  asynchronous active-low reset.
- i_Req_Valid  input  NUM_REQ  per-producer valid; bit k belongs to producer k.
- i_Req_Data  input  NUM_REQ*DATA_WIDTH  producer k data in bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_Req_Ready  output  NUM_REQ  per-producer ready; one-hot or zero.
- o_Wr_En  output  1  FIFO write enable.
- o_Wr_Data  output  DATA_WIDTH  FIFO write data.
- i_Full  input  1  FIFO full flag.
- o_Grant_Id  output  clog2(NUM_REQ)  index of the currently granted producer.
- o_Busy  output  1  high while in GRANT state.

Behaviour:
- Reset (async assert, sync release): state=IDLE, last_grant=NUM_REQ-1, beat_cnt=0.
  - Outputs at reset: o_Grant_Id=0, o_Busy=0, o_Req_Ready=0, o_Wr_En=0, o_Wr_Data=0.
- States: IDLE, GRANT. State, grant and beat_cnt are registered.
- IDLE:
  - If any i_Req_Valid bit is set, pick the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Load the picked index into the grant, set beat_cnt=0, go to GRANT.
  - Otherwise stay in IDLE.
  - Arbitration latency: 1 cycle from valid to grant.
- GRANT, combinational outputs:
  - o_Req_Ready[g] = ~i_Full; all other ready bits are 0.
  - o_Wr_En = i_Req_Valid[g] & ~i_Full.
  - o_Wr_Data = data of producer g whenever in GRANT; 0 in IDLE.
- Beat: a cycle where o_Wr_En=1. Each beat increments beat_cnt.
- Release conditions, evaluated each GRANT cycle:
  - (a) a beat occurs with beat_cnt==MAX_BURST-1, or
  - (b) i_Req_Valid[g]==0.
- On release: last_grant<=g, go to IDLE.
  - IDLE always lasts exactly 1 cycle when a request is pending, i.e. one bubble between grants.
- i_Full high in GRANT: no beat, no release, grant held. beat_cnt and state are unchanged.
- Producers hold valid and data stable until ready; dropping valid releases the grant.
- Non-granted producers never see ready. Their valid is ignored until selected.
- Single requester: re-granted to itself after the 1-cycle IDLE bubble.
- Fairness: every continuously-valid producer is granted within NUM_REQ grants.
- Reset asserted mid-burst: the in-flight beat is aborted and no write occurs. Next grant after release goes to producer 0.
- beat_cnt width is clog2(MAX_BURST+1). It never exceeds MAX_BURST-1.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state enum typedef (IDLE, GRANT);
  - localparam width helpers GNT_W=$clog2(NUM_REQ) and CNT_W=$clog2(MAX_BURST+1), supplied as functions.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: request vector and last index.
  - Outputs: any-request flag and picked index.
  - Instantiated once. The FSM, counter and muxing stay in fifo_wr_arbiter.

Test Plan (NUM_REQ=4, MAX_BURST=4, DATA_WIDTH=8, fifo_top ADDR_WIDTH=2):
- Reset, then producer 2 alone holds valid with data 0xA0..0xA2, dropping valid after 3 beats.
  - Expect grant id 2 one cycle after valid, 3 consecutive o_Wr_En pulses with 0xA0,0xA1,0xA2, then IDLE, o_Busy=0.
- All four producers continuously valid, FIFO drained every cycle.
  - Expect grant order 0,1,2,3,0; 4 beats each; exactly one idle cycle between grants.
- Producer 1 granted, i_Full forced high for 5 cycles after beat 2.
  - Expect o_Wr_En=0 and o_Req_Ready=0 during full, grant id stays 1, remaining 2 beats resume after full clears.
- Fill the 4-entry FIFO with no reads from producer 0 burst 0x10..0x13.
  - Expect i_Full high after beat 4; release after beat 4; read-back order 0x10..0x13 with no loss or duplication.
- Assert i_Rst_n low mid-burst of producer 3 (after beat 1).
  - Expect all outputs 0 immediately; after release with producers 0 and 3 valid, producer 0 is granted first.
- Producers 1 and 3 valid, 0 and 2 idle.
  - Expect strict alternation 1,3,1,3; producers 0 and 2 never see ready.
